// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  localparam int ITERS = 32;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with private HI/LO; MTHI/MTLO in one cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     opa, opb, abs_a, abs_b;
  logic [2*WIDTH-1:0]   acc, fix_in, fix_val;
  logic [CNTW-1:0]      cnt;
  logic                 neg_lo, neg_hi, is_div, done_q;
  logic                 accept, is_signed, last_step;
  logic [WIDTH:0]       add_x, add_y;
  logic                 add_sub;
  logic [WIDTH+1:0]     add_res;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = (state == S_IDLE) && start && !op[2];
  assign last_step = (cnt == CNTW'(ITERS));
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .x(a), .neg(is_signed & a[WIDTH-1]), .y(abs_a)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .x(b), .neg(is_signed & b[WIDTH-1]), .y(abs_b)
  );

  assign fix_in = is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
  cond_negate #(.WIDTH(2*WIDTH)) u_neg_fix (
    .x(fix_in), .neg(neg_lo), .y(fix_val)
  );

  // One 33-bit add/sub: product accumulate, remainder trial subtract,
  // and 0 - remainder for the sign fix of a negative dividend.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state)
      S_MUL: begin
        add_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_y = {1'b0, opa};
      end
      S_DIV: begin
        add_x   = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
        add_y   = {1'b0, opb};
        add_sub = 1'b1;
      end
      S_FIX: begin
        add_y   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_sub = 1'b1;
      end
      default: ;
    endcase
    add_res = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
            + (WIDTH+2)'(add_sub);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept) state_nxt = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (last_step) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            opa    <= abs_a;
            opb    <= abs_b;
            acc    <= '0;
            cnt    <= '0;
            is_div <= op[1];
            // Divide by zero keeps the all-ones quotient unnegated.
            neg_lo <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(op[1] & (b == '0));
            neg_hi <= is_signed & op[1] & a[WIDTH-1];
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        S_MUL: begin
          if (!last_step) begin
            cnt <= cnt + CNTW'(1);
            opb <= opb >> 1;
            if (opb[0]) acc <= {add_res[WIDTH:0], acc[WIDTH-1:1]};
            else        acc <= acc >> 1;
          end
        end
        S_DIV: begin
          if (!last_step) begin
            cnt <= cnt + CNTW'(1);
            opa <= opa << 1;
            if (add_res[WIDTH+1]) acc <= {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            lo <= fix_val[WIDTH-1:0];
            hi <= neg_hi ? add_res[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= fix_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an op at the current negedge and follows it to the done cycle.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo, input bit inject);
    logic [31:0] h0, l0;
    int bad;
    h0 = hi; l0 = lo; bad = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0) bad++;
      if (inject && i == 5) begin start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF; end
      if (inject && i == 6) start = 1'b0;
      @(negedge clk);
    end
    check({tag, " in-flight"}, 64'(bad), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    run("mult 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    // Issued in the done cycle of the previous op.
    run("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run("div 7/-2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    run("divu 100/0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 0);
    run("div -7/0", 3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run("div min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run("mult -5*-6", 3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 0);
    run("divu big", 3'b011, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 0);

    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);

    start = 1'b1; op = 3'b110; a = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    check("op110 hi", 64'(hi), 64'h1234_5678);
    check("op110 busy", 64'(busy), 64'd0);

    run("div busy mtlo", 3'b010, 32'd20, 32'd3, 32'd2, 32'd6, 1);

    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort no done", 64'(bad), 64'd0);

    run("mult 3*4", 3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
